// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control FSM.
// Opcodes, state encoding, datapath mux selects and the control word.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_SEXT    = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

  // Codes 14 and 15 are unused and recover to S_IDLE.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_RTYPE_EX = 4'd7,
    S_RTYPE_WB = 4'd8,
    S_BEQ      = 4'd9,
    S_JUMP     = 4'd10,
    S_JAL      = 4'd11,
    S_ADDI_EX  = 4'd12,
    S_ADDI_WB  = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       jal;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Moore control word for each FSM state; mem_ready only qualifies the
// FETCH write strobes and the sw completion so stalls keep strobes low.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.pc_write  = mem_ready;
        ctrl.ir_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        ctrl.alu_src_b = SRCB_SEXT_SH;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.retire     = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retire    = mem_ready;
      end
      S_RTYPE_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTYPE_WB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.retire        = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.retire    = 1'b1;
      end
      S_JAL: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.reg_write = 1'b1;
        ctrl.jal       = 1'b1;
        ctrl.retire    = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retire    = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, opcode latch, next-state
// logic, illegal-opcode flag and retired-instruction counter.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int CNT_W    = 32,
  parameter bit EN_ADDI  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_source,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                jal,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                illegal,
  output logic                retire,
  output logic [CNT_W-1:0]    instr_count,
  output logic [3:0]          state
);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic                illegal_c;
  ctrl_t               ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // MEMADR needs lw/sw after the IR may have moved on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  op_q <= '0;
    else if (state_q == S_DECODE) op_q <= opcode;
  end

  always_comb begin
    state_d   = state_q;
    illegal_c = 1'b0;
    case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OPCODE_W'(OP_RTYPE): state_d = S_RTYPE_EX;
          OPCODE_W'(OP_LW),
          OPCODE_W'(OP_SW):    state_d = S_MEMADR;
          OPCODE_W'(OP_BEQ):   state_d = S_BEQ;
          OPCODE_W'(OP_J):     state_d = S_JUMP;
          OPCODE_W'(OP_JAL):   state_d = S_JAL;
          OPCODE_W'(OP_ADDI): begin
            if (EN_ADDI) state_d = S_ADDI_EX;
            else begin
              illegal_c = 1'b1;
              state_d   = S_FETCH;
            end
          end
          default: begin
            illegal_c = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR:   state_d = (op_q == OPCODE_W'(OP_LW)) ? S_MEMRD : S_MEMWR;
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:    if (mem_ready) state_d = S_FETCH;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_MEMWB, S_RTYPE_WB, S_BEQ, S_JUMP, S_JAL, S_ADDI_WB: state_d = S_FETCH;
      default:    state_d = S_IDLE;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instr_count <= '0;
    else if (ctrl.retire) instr_count <= instr_count + CNT_W'(1);
  end

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_source     = ctrl.pc_source;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign jal           = ctrl.jal;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign retire        = ctrl.retire;
  assign illegal       = illegal_c;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench: the driver pushes a hand-written expected control word
// per cycle; a negedge monitor pops and compares against the DUT.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, reg_write, mem_to_reg, jal, alu_src_a, illegal, retire;
  logic [1:0]  pc_source, alu_src_b, alu_op;
  logic [31:0] instr_count;
  logic [3:0]  state;

  always #5 clk = ~clk;

  multicycle_control #(.OPCODE_W(6), .CNT_W(32), .EN_ADDI(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .jal(jal),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .illegal(illegal), .retire(retire), .instr_count(instr_count), .state(state)
  );

  // Control-word bit flags, MSB first: pc_write .. retire.
  localparam logic [18:0] C_PCW   = 19'b1 << 18;
  localparam logic [18:0] C_PCWC  = 19'b1 << 17;
  localparam logic [18:0] C_PCS1  = 19'b1 << 15;
  localparam logic [18:0] C_PCS2  = 19'b10 << 15;
  localparam logic [18:0] C_IORD  = 19'b1 << 14;
  localparam logic [18:0] C_MRD   = 19'b1 << 13;
  localparam logic [18:0] C_MWR   = 19'b1 << 12;
  localparam logic [18:0] C_IRW   = 19'b1 << 11;
  localparam logic [18:0] C_RDST  = 19'b1 << 10;
  localparam logic [18:0] C_RWR   = 19'b1 << 9;
  localparam logic [18:0] C_M2R   = 19'b1 << 8;
  localparam logic [18:0] C_JAL   = 19'b1 << 7;
  localparam logic [18:0] C_SRCA  = 19'b1 << 6;
  localparam logic [18:0] C_B4    = 19'b01 << 4;
  localparam logic [18:0] C_BSX   = 19'b10 << 4;
  localparam logic [18:0] C_BSH   = 19'b11 << 4;
  localparam logic [18:0] C_SUB   = 19'b01 << 2;
  localparam logic [18:0] C_FN    = 19'b10 << 2;
  localparam logic [18:0] C_ILL   = 19'b1 << 1;
  localparam logic [18:0] C_RET   = 19'b1;

  localparam logic [18:0] E_FETCH  = C_MRD | C_B4 | C_PCW | C_IRW;
  localparam logic [18:0] E_FSTALL = C_MRD | C_B4;
  localparam logic [18:0] E_DEC    = C_BSH;

  typedef struct {
    logic [3:0]  st;
    logic [18:0] ctl;
    logic [31:0] cnt;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          step_id = 0;
  logic [31:0] exp_cnt = 0;

  task automatic step(input logic [3:0] st, input logic [18:0] ctl,
                      input logic [5:0] op, input logic mr);
    exp_t e;
    opcode    = op;
    mem_ready = mr;
    e.st = st; e.ctl = ctl; e.cnt = exp_cnt; e.id = step_id;
    sb.push_back(e);
    step_id++;
    if (ctl[0]) exp_cnt = exp_cnt + 1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [18:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write,
             ir_write, reg_dst, reg_write, mem_to_reg, jal, alu_src_a,
             alu_src_b, alu_op, illegal, retire};
      checks += 3;
      if (state !== e.st) begin
        failures++;
        $display("FAIL state step=%0d got=%0d want=%0d", e.id, state, e.st);
      end
      if (act !== e.ctl) begin
        failures++;
        $display("FAIL ctrl step=%0d got=%b want=%b", e.id, act, e.ctl);
      end
      if (instr_count !== e.cnt) begin
        failures++;
        $display("FAIL count step=%0d got=%0d want=%0d", e.id, instr_count, e.cnt);
      end
    end
  end

  initial begin
    rst_n = 1'b0; opcode = '0; mem_ready = 1'b0;
    @(posedge clk); #1;
    // Reset held: IDLE, all zero.
    repeat (3) step(S_IDLE, '0, 6'h00, 1'b0);
    rst_n = 1'b1;
    step(S_IDLE, '0, 6'h00, 1'b1);
    // R-type
    step(S_FETCH, E_FETCH, 6'h00, 1'b1);
    step(S_DECODE, E_DEC, OP_RTYPE, 1'b1);
    step(S_RTYPE_EX, C_SRCA | C_FN, 6'h00, 1'b1);
    step(S_RTYPE_WB, C_RDST | C_RWR | C_RET, 6'h00, 1'b1);
    // lw with fetch stall and 3-cycle MEMRD stall; opcode scrambled after DECODE
    step(S_FETCH, E_FSTALL, 6'h00, 1'b0);
    step(S_FETCH, E_FETCH, 6'h00, 1'b1);
    step(S_DECODE, E_DEC, OP_LW, 1'b1);
    step(S_MEMADR, C_SRCA | C_BSX, 6'h3F, 1'b1);
    repeat (3) step(S_MEMRD, C_MRD | C_IORD, 6'h3F, 1'b0);
    step(S_MEMRD, C_MRD | C_IORD, 6'h3F, 1'b1);
    step(S_MEMWB, C_RWR | C_M2R | C_RET, 6'h3F, 1'b1);
    // sw with 2-cycle write stall
    step(S_FETCH, E_FETCH, 6'h00, 1'b1);
    step(S_DECODE, E_DEC, OP_SW, 1'b1);
    step(S_MEMADR, C_SRCA | C_BSX, OP_LW, 1'b1);
    repeat (2) step(S_MEMWR, C_MWR | C_IORD, 6'h00, 1'b0);
    step(S_MEMWR, C_MWR | C_IORD | C_RET, 6'h00, 1'b1);
    // illegal opcode
    step(S_FETCH, E_FETCH, 6'h00, 1'b1);
    step(S_DECODE, E_DEC | C_ILL, 6'h3F, 1'b1);
    // beq
    step(S_FETCH, E_FETCH, 6'h00, 1'b1);
    step(S_DECODE, E_DEC, OP_BEQ, 1'b1);
    step(S_BEQ, C_SRCA | C_SUB | C_PCWC | C_PCS1 | C_RET, 6'h00, 1'b1);
    // j
    step(S_FETCH, E_FETCH, 6'h00, 1'b1);
    step(S_DECODE, E_DEC, OP_J, 1'b1);
    step(S_JUMP, C_PCW | C_PCS2 | C_RET, 6'h00, 1'b1);
    // jal
    step(S_FETCH, E_FETCH, 6'h00, 1'b1);
    step(S_DECODE, E_DEC, OP_JAL, 1'b1);
    step(S_JAL, C_PCW | C_PCS2 | C_RWR | C_JAL | C_RET, 6'h00, 1'b1);
    // addi
    step(S_FETCH, E_FETCH, 6'h00, 1'b1);
    step(S_DECODE, E_DEC, OP_ADDI, 1'b1);
    step(S_ADDI_EX, C_SRCA | C_BSX, 6'h00, 1'b1);
    step(S_ADDI_WB, C_RWR | C_RET, 6'h00, 1'b1);
    // sw interrupted by reset while waiting on memory
    step(S_FETCH, E_FETCH, 6'h00, 1'b1);
    step(S_DECODE, E_DEC, OP_SW, 1'b1);
    step(S_MEMADR, C_SRCA | C_BSX, 6'h00, 1'b0);
    step(S_MEMWR, C_MWR | C_IORD, 6'h00, 1'b0);
    rst_n   = 1'b0;
    exp_cnt = 0;
    step(S_IDLE, '0, 6'h00, 1'b1);
    step(S_IDLE, '0, 6'h00, 1'b1);
    rst_n = 1'b1;
    step(S_IDLE, '0, 6'h00, 1'b1);
    step(S_FETCH, E_FETCH, 6'h00, 1'b1);
    step(S_DECODE, E_DEC, OP_J, 1'b1);
    step(S_JUMP, C_PCW | C_PCS2 | C_RET, 6'h00, 1'b1);
    step(S_FETCH, E_FETCH, 6'h00, 1'b1);
    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
